// File: rtl/instr_exec_reader.sv
// rtl/instr_exec_reader.sv - fetches instructions from a register file and executes them one at a time
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start, first_addr,    run request, first register entry, instruction count (0..32);
//   count                 sampled only while idle
//   read_pointer          entry address presented to the instruction register
//   instruction_word      combinational register contents at read_pointer
//   result, result_opcode,
//   div_by_zero           registered execution result, held while result_valid is high
//   result_valid,
//   result_ready          output handshake; transfer when both are high at a posedge
//   busy, done            busy outside IDLE; done pulses for one cycle at end of a run

package instr_register_pkg;
  typedef enum logic [2:0] {
    ZERO  = 3'd0,
    PASSA = 3'd1,
    PASSB = 3'd2,
    ADD   = 3'd3,
    SUB   = 3'd4,
    MULT  = 3'd5,
    DIV   = 3'd6,
    MOD   = 3'd7
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic [4:0]         address_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;
endpackage

module instr_exec_reader
  import instr_register_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  address_t           first_addr,
  input  logic [5:0]         count,
  output address_t           read_pointer,
  input  instruction_t       instruction_word,
  output logic signed [63:0] result,
  output opcode_t            result_opcode,
  output logic               div_by_zero,
  output logic               result_valid,
  input  logic               result_ready,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  address_t            ptr_q, ptr_d;
  logic [5:0]          remaining_q, remaining_d;
  instruction_t        instr_q, instr_d;
  logic signed [63:0]  result_q, result_d;
  opcode_t             opc_q, opc_d;
  logic                dbz_q, dbz_d;

  // Execution datapath on the registered instruction
  logic signed [63:0]  op_a_ext, op_b_ext, op_b_safe;
  logic signed [63:0]  alu_result;
  logic                alu_dbz;

  always_comb begin
    op_a_ext  = {{32{instr_q.op_a[31]}}, instr_q.op_a};
    op_b_ext  = {{32{instr_q.op_b[31]}}, instr_q.op_b};
    // Divisor replaced by 1 when zero so the divider never sees 0; the
    // result is overridden below anyway.
    op_b_safe = (instr_q.op_b == 32'sd0) ? 64'sd1 : op_b_ext;
    alu_dbz    = 1'b0;
    alu_result = 64'sd0;
    case (instr_q.opc)
      ZERO:  alu_result = 64'sd0;
      PASSA: alu_result = op_a_ext;
      PASSB: alu_result = op_b_ext;
      ADD:   alu_result = op_a_ext + op_b_ext;
      SUB:   alu_result = op_a_ext - op_b_ext;
      MULT:  alu_result = op_a_ext * op_b_ext;
      // 64-bit operands make -2^31 / -1 representable as +2^31
      DIV: begin
        if (instr_q.op_b == 32'sd0) begin
          alu_dbz = 1'b1;
        end else begin
          alu_result = op_a_ext / op_b_safe;
        end
      end
      MOD: begin
        if (instr_q.op_b == 32'sd0) begin
          alu_dbz = 1'b1;
        end else begin
          alu_result = op_a_ext % op_b_safe;
        end
      end
      default: alu_result = 64'sd0;
    endcase
  end

  // Next-state and datapath register control
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    instr_d     = instr_q;
    result_d    = result_q;
    opc_d       = opc_q;
    dbz_d       = dbz_q;
    case (state_q)
      IDLE: begin
        if (start && (count != 6'd0)) begin
          state_d     = FETCH;
          ptr_d       = first_addr;
          remaining_d = count;
        end
      end
      FETCH: begin
        instr_d = instruction_word;
        state_d = EXEC;
      end
      EXEC: begin
        result_d = alu_result;
        opc_d    = instr_q.opc;
        dbz_d    = alu_dbz;
        state_d  = HOLD;
      end
      HOLD: begin
        if (result_ready) begin
          if (remaining_q == 6'd1) begin
            state_d = DONE;
          end else begin
            remaining_d = remaining_q - 6'd1;
            ptr_d       = ptr_q + 5'd1;   // wraps 31 -> 0
            state_d     = FETCH;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      remaining_q <= '0;
      instr_q     <= '0;
      result_q    <= '0;
      opc_q       <= ZERO;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      instr_q     <= instr_d;
      result_q    <= result_d;
      opc_q       <= opc_d;
      dbz_q       <= dbz_d;
    end
  end

  assign read_pointer  = ptr_q;
  assign result        = result_q;
  assign result_opcode = opc_q;
  assign div_by_zero   = dbz_q;
  assign result_valid  = (state_q == HOLD);
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);

endmodule

// File: tb/tb_instr_exec_reader.sv
// tb/tb_instr_exec_reader.sv - self-checking bench for instr_exec_reader
module tb_instr_exec_reader;
  import instr_register_pkg::*;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               start;
  address_t           first_addr;
  logic [5:0]         count;
  address_t           read_pointer;
  instruction_t       instruction_word;
  logic signed [63:0] result;
  opcode_t            result_opcode;
  logic               div_by_zero;
  logic               result_valid;
  logic               result_ready;
  logic               busy;
  logic               done;

  instruction_t mem [32];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign instruction_word = mem[read_pointer];

  instr_exec_reader dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .first_addr       (first_addr),
    .count            (count),
    .read_pointer     (read_pointer),
    .instruction_word (instruction_word),
    .result           (result),
    .result_opcode    (result_opcode),
    .div_by_zero      (div_by_zero),
    .result_valid     (result_valid),
    .result_ready     (result_ready),
    .busy             (busy),
    .done             (done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic instruction_t mk(input opcode_t o, input int a, input int b);
    instruction_t t;
    t.opc  = o;
    t.op_a = a;
    t.op_b = b;
    return t;
  endfunction

  // Reference: plain 64-bit integer arithmetic on sign-extended operands
  function automatic void model(input instruction_t ins, output logic [63:0] r, output logic dz);
    longint a, b, res;
    a   = longint'($signed(ins.op_a));
    b   = longint'($signed(ins.op_b));
    res = 0;
    dz  = 1'b0;
    case (ins.opc)
      PASSA: res = a;
      PASSB: res = b;
      ADD:   res = a + b;
      SUB:   res = a - b;
      MULT:  res = a * b;
      DIV:   if (b == 0) dz = 1'b1; else res = a / b;
      MOD:   if (b == 0) dz = 1'b1; else res = a % b;
      default: res = 0;
    endcase
    r = res;
  endfunction

  function automatic int rand_operand();
    case ($urandom_range(0, 5))
      0: return 0;
      1: return -1;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20) - 10;
      default: return $urandom;
    endcase
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 32; i++)
      mem[i] = mk(opcode_t'($urandom_range(0, 7)), rand_operand(), rand_operand());
  endtask

  // Runs one program from a negedge; stall_fixed < 0 selects random stalls.
  // Start is pulsed with junk during stalls and must not disturb the run.
  task automatic run_prog(input int first, input int cnt, input int stall_fixed);
    logic [63:0] er;
    logic        ed;
    int          addr, cyc, stall;
    start      = 1'b1;
    first_addr = address_t'(first);
    count      = 6'(cnt);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    for (int i = 0; i < cnt; i++) begin
      addr = (first + i) % 32;
      model(mem[addr], er, ed);
      cyc = 0;
      while (result_valid !== 1'b1 && cyc < 8) begin
        @(negedge clk);
        cyc++;
      end
      chk("latency", 64'(cyc), 64'd2);
      chk("read_pointer", 64'(read_pointer), 64'(addr));
      chk("result", result, er);
      chk("result_opcode", 64'(result_opcode), 64'(mem[addr].opc));
      chk("div_by_zero", 64'(div_by_zero), 64'(ed));
      stall = (stall_fixed < 0) ? $urandom_range(0, 3) : stall_fixed;
      repeat (stall) begin
        result_ready = 1'b0;
        start      = $urandom_range(0, 1);
        first_addr = address_t'($urandom);
        count      = 6'($urandom_range(1, 32));
        @(negedge clk);
        start = 1'b0;
        chk("hold_valid", 64'(result_valid), 64'd1);
        chk("hold_result", result, er);
      end
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
      chk("valid_drop", 64'(result_valid), 64'd0);
    end
    chk("done_pulse", 64'(done), 64'd1);
    chk("busy_in_done", 64'(busy), 64'd1);
    @(negedge clk);
    chk("done_clear", 64'(done), 64'd0);
    chk("busy_clear", 64'(busy), 64'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 64'(result_valid), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_result"}, result, 64'd0);
    chk({tag, "_opcode"}, 64'(result_opcode), 64'(ZERO));
    chk({tag, "_dbz"}, 64'(div_by_zero), 64'd0);
    chk({tag, "_ptr"}, 64'(read_pointer), 64'd0);
  endtask

  initial begin
    reset_n      = 1'b0;
    start        = 1'b0;
    first_addr   = '0;
    count        = '0;
    result_ready = 1'b0;
    fill_random();
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Single ADD at entry 3
    mem[3] = mk(ADD, 5, -7);
    run_prog(3, 1, 0);
    chk("add_result_kept", result, -64'sd2);

    // Wrap of read_pointer across 31 -> 0
    mem[30] = mk(MULT, -3, 4);
    mem[31] = mk(SUB, 10, 20);
    mem[0]  = mk(MOD, -7, 3);
    run_prog(30, 3, 0);
    chk("mod_result_kept", result, -64'sd1);

    // Divide by zero, then the overflow-free -2^31 / -1
    mem[0] = mk(DIV, 9, 0);
    mem[1] = mk(DIV, 32'h8000_0000, -1);
    run_prog(0, 2, 0);
    chk("div_ovf_result", result, 64'sd2147483648);
    chk("div_ovf_dbz", 64'(div_by_zero), 64'd0);

    // Five-cycle back-pressure with start pulses during the stall
    fill_random();
    run_prog(7, 2, 5);

    // count = 0 is ignored
    start = 1'b1;
    count = 6'd0;
    first_addr = 5'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (4) begin
      chk("cnt0_busy", 64'(busy), 64'd0);
      chk("cnt0_valid", 64'(result_valid), 64'd0);
      chk("cnt0_done", 64'(done), 64'd0);
      @(negedge clk);
    end

    // Full 32-entry run from address 0
    fill_random();
    run_prog(0, 32, -1);
    chk("full_run_ptr", 64'(read_pointer), 64'd31);

    // Random programs with random stalls
    for (int r = 0; r < 5; r++) begin
      fill_random();
      run_prog($urandom_range(0, 31), $urandom_range(1, 10), -1);
    end

    // Reset during EXEC of the 2nd of 4 instructions
    fill_random();
    result_ready = 1'b1;
    start      = 1'b1;
    first_addr = 5'd0;
    count      = 6'd4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_valid", 64'(result_valid), 64'd1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("midrun_reset");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("post_reset_valid", 64'(result_valid), 64'd0);
      chk("post_reset_busy", 64'(busy), 64'd0);
    end
    result_ready = 1'b0;
    run_prog(5, 3, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
